// File: rtl/muldiv_unit_if.sv
// Pipeline-side bundle for the iterative multiply/divide unit: operation request,
// MTHI/MTLO writes, stall request and the HI/LO result registers.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             flush_i;
    logic             hi_we_i;
    logic             lo_we_i;
    logic [WIDTH-1:0] wdata_i;
    logic             stall_req_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i, flush_i, hi_we_i, lo_we_i, wdata_i,
        input  stall_req_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i, hi_we_i, lo_we_i, wdata_i,
        output stall_req_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: magnitudes are processed one bit
// per cycle (shift-add or restoring division) and the sign is fixed up on completion.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     opnd_r;
    logic [WIDTH-1:0]     a_r;
    logic                 is_div_r;
    logic                 neg_res_r;
    logic                 neg_rem_r;
    logic                 div_zero_r;
    logic                 done_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;

    logic                 signed_op_s;
    logic                 a_neg_s;
    logic                 b_neg_s;
    logic [WIDTH-1:0]     abs_a_s;
    logic [WIDTH-1:0]     abs_b_s;
    logic                 accept_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic [WIDTH:0]       div_shift_s;
    logic [WIDTH:0]       div_diff_s;
    logic [2*WIDTH-1:0]   div_next_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     res_hi_s;
    logic [WIDTH-1:0]     res_lo_s;

    // Operand decode: magnitudes and sign flags captured at start
    always_comb begin
        signed_op_s = ~bus.op_i[0];
        a_neg_s     = signed_op_s & bus.a_i[WIDTH-1];
        b_neg_s     = signed_op_s & bus.b_i[WIDTH-1];
        if (a_neg_s) begin
            abs_a_s = -bus.a_i;
        end else begin
            abs_a_s = bus.a_i;
        end
        if (b_neg_s) begin
            abs_b_s = -bus.b_i;
        end else begin
            abs_b_s = bus.b_i;
        end
        accept_s = (state_r == IDLE) & bus.start_i & ~bus.flush_i;
    end

    // One iteration step; acc holds {partial, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        if (!div_diff_s[WIDTH]) begin
            div_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction and divide-by-zero override applied in DONE
    always_comb begin
        if (neg_res_r) begin
            prod_s = -acc_r;
        end else begin
            prod_s = acc_r;
        end
        if (!is_div_r) begin
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end else if (div_zero_r) begin
            res_hi_s = a_r;
            res_lo_s = {WIDTH{1'b1}};
        end else begin
            if (neg_res_r) begin
                res_lo_s = -acc_r[WIDTH-1:0];
            end else begin
                res_lo_s = acc_r[WIDTH-1:0];
            end
            if (neg_rem_r) begin
                res_hi_s = -acc_r[2*WIDTH-1:WIDTH];
            end else begin
                res_hi_s = acc_r[2*WIDTH-1:WIDTH];
            end
        end
    end

    // Control FSM, datapath registers and HI/LO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            opnd_r     <= {WIDTH{1'b0}};
            a_r        <= {WIDTH{1'b0}};
            is_div_r   <= 1'b0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
            done_r     <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.hi_we_i) begin
                        hi_r <= bus.wdata_i;
                    end
                    if (bus.lo_we_i) begin
                        lo_r <= bus.wdata_i;
                    end
                    if (accept_s) begin
                        state_r    <= RUN;
                        cnt_r      <= {CNT_W{1'b0}};
                        is_div_r   <= bus.op_i[1];
                        neg_res_r  <= a_neg_s ^ b_neg_s;
                        neg_rem_r  <= a_neg_s;
                        a_r        <= bus.a_i;
                        div_zero_r <= (bus.b_i == {WIDTH{1'b0}});
                        if (bus.op_i[1]) begin
                            acc_r  <= {{WIDTH{1'b0}}, abs_a_s};
                            opnd_r <= abs_b_s;
                        end else begin
                            acc_r  <= {{WIDTH{1'b0}}, abs_b_s};
                            opnd_r <= abs_a_s;
                        end
                    end
                end
                RUN: begin
                    if (bus.flush_i) begin
                        state_r <= IDLE;
                        done_r  <= 1'b0;
                    end else begin
                        acc_r <= is_div_r ? div_next_s : mul_next_s;
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_r == CNT_W'(WIDTH - 1)) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    if (!bus.flush_i) begin
                        hi_r <= res_hi_s;
                        lo_r <= res_lo_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall_req_o = rst_n & ~bus.flush_i &
                             (((state_r == IDLE) & bus.start_i) | (state_r == RUN));
    assign bus.done_o      = rst_n & done_r & ~bus.flush_i;
    assign bus.hi_o        = hi_r;
    assign bus.lo_o        = lo_r;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the 5-cycle MIPS pipeline. It owns the HI/LO registers.
- It executes MULT, MULTU, DIV and DIVU over multiple cycles. While busy it raises stall_req to the hazard logic, which holds F/D/E.
- It is the requesting side of the stall interface: the hazard block consumes stall_req and drives flush back via flush_i.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start_i  input  1  a valid mul/div instruction occupies EX this cycle.
- op_i  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a_i  input  WIDTH  rs operand (forwarded value).
- b_i  input  WIDTH  rt operand (forwarded value).
- flush_i  input  1  cancel the in-flight operation (exception or flushE of a cancelled instruction).
- hi_we_i  input  1  MTHI write enable.
- lo_we_i  input  1  MTLO write enable.
- wdata_i  input  WIDTH  MTHI/MTLO data.
- stall_req_o  output  1  hold F/D/E this cycle.
- done_o  output  1  one-cycle pulse: HI/LO updated by a mul/div.
- hi_o  output  WIDTH  HI register.
- lo_o  output  WIDTH  LO register.

Behaviour:
- Reset: synchronous, active-low, one clock, one reset. While rst_n=0 at a clk edge:
  - state goes to IDLE, cnt=0;
  - hi_o=0, lo_o=0, done_o=0;
  - stall_req_o=0 combinationally during reset.
  - Reset mid-operation abandons the operation with no HI/LO update.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start_i=1 and flush_i=0: latch |a|, |b| (absolute values only for signed ops), the result sign flags and op; cnt=0; go to RUN.
  - stall_req_o = start_i & ~flush_i, combinational, asserted in the same cycle as start.
- RUN:
  - Multiply: one shift-add step per cycle on a 2*WIDTH accumulator.
  - Divide: one restoring-division step per cycle (shift remainder, trial subtract, set quotient bit).
  - cnt increments each cycle. When cnt==WIDTH-1, go to DONE next cycle.
  - stall_req_o=1 throughout.
- DONE:
  - stall_req_o=0, done_o=1, so the instruction advances out of EX this cycle.
  - HI/LO take the sign-corrected result at the end of this cycle. Next state is IDLE.
  - start_i is ignored in DONE; it refers to the completing instruction.
- Latency:
  - stall_req_o is high for exactly WIDTH+1 consecutive cycles (33 at default).
  - done_o pulses on cycle WIDTH+2 counted from the start cycle as cycle 1.
  - Back-to-back ops: the next start is accepted the cycle after DONE.
- Result rules:
  - MULT/MULTU: {HI,LO} = full 2*WIDTH-bit product. MULT negates the product if the operand signs differ.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - DIV: quotient negated if signs differ; remainder takes the sign of the dividend (truncating division).
  - Divide by zero: fixed result LO=all ones, HI=dividend (a_i as latched, original sign). Same latency; no exception.
  - DIV of -2^(WIDTH-1) by -1: LO=0x80000000, HI=0 (wraps).
- flush_i:
  - In RUN or DONE: next state IDLE, HI/LO unchanged, done_o=0, and stall_req_o drops combinationally that cycle.
  - In IDLE: blocks start.
  - flush_i has priority over start_i.
- MTHI/MTLO:
  - Write at the clk edge when state==IDLE.
  - hi_we_i/lo_we_i in RUN are ignored. They cannot occur, because the pipeline is stalled; the bench asserts this.
  - A DONE-cycle result write and a same-cycle MTHI/MTLO are mutually exclusive; the result has priority.
- hi_o/lo_o are registered outputs, stable except on a DONE update, an MTHI/MTLO write, or reset.

Test Plan:
- MULTU a=0xFFFFFFFF, b=2 -> stall_req_o high 33 cycles; done_o pulse; hi=0x00000001, lo=0xFFFFFFFE.
- MULT a=-3 (0xFFFFFFFD), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Back-to-back DIVU 100/7 accepted the cycle after DONE -> lo=14, hi=2.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x00001234 after normal latency.
- Pre-load via MTHI=0xAAAA, MTLO=0x5555. Start MULTU, assert flush_i in RUN cycle 10 -> stall_req_o low that cycle; IDLE next; hi/lo remain 0xAAAA/0x5555; no done_o.
- rst_n=0 during RUN cycle 20 -> next edge: hi=lo=0, state IDLE, stall_req_o=0. start+flush in the same cycle -> no stall, no operation.
